td4_run_controller: RTL and testbench

- Program sequencer for the 4-bit accumulator CPU core.
- Holds the 16x8 program memory and loads it byte-serially from external pins.
- Serves instructions combinationally to the core's address bus.
- Gates the core with a one-cycle enable pulse (run / single-step / halt) and drives its active-low reset, so the core never sees a gated clock.

---
 rtl/td4_run_controller.sv | 181 ++++++++++++++++++
 tb/tb_td4_run_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_run_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | td4_run_controller: program memory, loader and run/step/halt sequencer   |
// | for the 4-bit accumulator core. Optional breakpoint: TD4_CTRL_BREAK_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module td4_run_controller #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             i_cmd_valid,
  input  logic [2:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_wr_valid,
  input  logic [7:0]       i_wr_data,
  input  logic [3:0]       i_cpu_address,
  output logic [7:0]       o_cpu_instr,
  output logic             o_cpu_en,
  output logic             o_cpu_n_rst,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_exec_count
`ifdef TD4_CTRL_BREAK_EN
  ,
  input  logic             i_bp_en,
  input  logic [3:0]       i_bp_addr,
  output logic             o_bp_hit
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  localparam logic [2:0]       c_CMD_LOAD = 3'd1;
  localparam logic [2:0]       c_CMD_RUN  = 3'd2;
  localparam logic [2:0]       c_CMD_STEP = 3'd3;
  localparam logic [2:0]       c_CMD_HALT = 3'd4;
  localparam logic [2:0]       c_CMD_CRST = 3'd5;
  localparam logic [3:0]       c_DIV_LAST = 4'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_wr_ptr;
  logic [3:0]       r_div_cnt;
  logic [1:0]       r_rst_cnt;
  logic [CNT_W-1:0] r_exec_cnt;
  logic [7:0]       r_mem [16];

  logic w_core_live;
  logic w_accept;
  logic w_tick;
  logic w_bp;
  logic w_wr_en;
  logic w_ptr_clr;
  logic w_div_clr;
  logic w_rst_req;

  assign w_core_live = (r_rst_cnt == 2'd0);
  assign o_cmd_ready = w_core_live && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_tick      = (r_state == ST_RUN) && (r_div_cnt == c_DIV_LAST) && w_core_live;
  assign w_wr_en     = (r_state == ST_LOAD) && i_wr_valid;

`ifdef TD4_CTRL_BREAK_EN
  // A breakpoint steals the tick: the instruction at bp_addr stays unexecuted.
  assign w_bp     = w_tick && i_bp_en && (i_cpu_address == i_bp_addr);
  assign o_bp_hit = w_bp;
`else
  assign w_bp     = 1'b0;
`endif

  assign o_cpu_en     = (w_tick && !w_bp) || (r_state == ST_STEP);
  assign o_cpu_n_rst  = w_core_live;
  assign o_state      = r_state;
  assign o_exec_count = r_exec_cnt;
  assign o_cpu_instr  = r_mem[i_cpu_address];

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_clr   = 1'b0;
    w_div_clr   = 1'b0;
    w_rst_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (i_cmd)
            c_CMD_LOAD: begin
              w_state_nxt = ST_LOAD;
              w_ptr_clr   = 1'b1;
            end
            c_CMD_RUN: begin
              w_state_nxt = ST_RUN;
              w_div_clr   = 1'b1;
            end
            c_CMD_STEP: w_state_nxt = ST_STEP;
            c_CMD_CRST: w_rst_req   = 1'b1;
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (w_wr_en && (r_wr_ptr == 4'd15)) begin
          w_state_nxt = ST_IDLE;
          w_rst_req   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_accept && (i_cmd == c_CMD_HALT)) begin
          w_state_nxt = ST_IDLE;
        end
        if (w_accept && (i_cmd == c_CMD_CRST)) begin
          w_rst_req = 1'b1;
          w_div_clr = 1'b1;
        end
        if (w_bp) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STEP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr   <= 4'd0;
      r_div_cnt  <= 4'd0;
      r_rst_cnt  <= 2'd2;
      r_exec_cnt <= '0;
    end else begin
      // The pointer parks at 15 after the last byte so a load is single-pass.
      if (w_ptr_clr) begin
        r_wr_ptr <= 4'd0;
      end else if (w_wr_en && (r_wr_ptr != 4'd15)) begin
        r_wr_ptr <= r_wr_ptr + 4'd1;
      end

      if (w_div_clr) begin
        r_div_cnt <= 4'd0;
      end else if (r_state == ST_RUN) begin
        r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? 4'd0 : r_div_cnt + 4'd1;
      end

      if (w_rst_req) begin
        r_rst_cnt <= 2'd2;
      end else if (!w_core_live) begin
        r_rst_cnt <= r_rst_cnt - 2'd1;
      end

      // A clear request outranks a pulse issued in the same cycle.
      if (w_rst_req) begin
        r_exec_cnt <= '0;
      end else if (o_cpu_en && (r_exec_cnt != c_CNT_MAX)) begin
        r_exec_cnt <= r_exec_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_td4_run_controller.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for td4_run_controller: a cycle table plus hand sequences
// for saturation, reset during LOAD and (when enabled) the breakpoint.
module tb_td4_run_controller;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_LOAD = 3'd1;
  localparam logic [2:0] C_RUN  = 3'd2;
  localparam logic [2:0] C_STEP = 3'd3;
  localparam logic [2:0] C_HALT = 3'd4;
  localparam logic [2:0] C_CRST = 3'd5;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic       cv = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic       wv = 1'b0;
  logic [7:0] wd = 8'd0;
  logic [3:0] addr = 4'd0;
  logic       rdy, en, nrst;
  logic [7:0] instr;
  logic [1:0] st;
  logic [7:0] cnt;
`ifdef TD4_CTRL_BREAK_EN
  logic       bp_en = 1'b0;
  logic [3:0] bp_addr = 4'd0;
  logic       bp_hit;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  td4_run_controller #(.TICK_DIV(4), .CNT_W(8)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .i_cmd_valid  (cv),
    .i_cmd        (cmd),
    .o_cmd_ready  (rdy),
    .i_wr_valid   (wv),
    .i_wr_data    (wd),
    .i_cpu_address(addr),
    .o_cpu_instr  (instr),
    .o_cpu_en     (en),
    .o_cpu_n_rst  (nrst),
    .o_state      (st),
    .o_exec_count (cnt)
`ifdef TD4_CTRL_BREAK_EN
    ,
    .i_bp_en      (bp_en),
    .i_bp_addr    (bp_addr),
    .o_bp_hit     (bp_hit)
`endif
  );

  typedef struct {
    string      name;
    logic       cv;
    logic [2:0] cmd;
    logic       wv;
    logic [7:0] wd;
    logic [3:0] addr;
    logic       en;
    logic       nrst;
    logic       rdy;
    logic [1:0] st;
    logic [7:0] cnt;
    logic       ci;
    logic [7:0] instr;
  } vec_t;

  vec_t q[$];

  function automatic void add(input string nm, input logic cv_, input logic [2:0] cmd_,
                              input logic wv_, input logic [7:0] wd_, input logic [3:0] addr_,
                              input logic en_, input logic nrst_, input logic rdy_,
                              input logic [1:0] st_, input logic [7:0] cnt_,
                              input logic ci_, input logic [7:0] instr_);
    vec_t v;
    v.name = nm;  v.cv = cv_;   v.cmd = cmd_;   v.wv = wv_;   v.wd = wd_;
    v.addr = addr_; v.en = en_; v.nrst = nrst_; v.rdy = rdy_; v.st = st_;
    v.cnt = cnt_; v.ci = ci_;   v.instr = instr_;
    q.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset release: core held 2 cycles; a RUN offered while not ready is dropped.
    add("rst_c0",        0, C_NOP,  0, 8'h00, 4'd0, 0, 0, 0, 2'd0, 8'd0, 0, 8'h00);
    add("rst_c1_norun",  1, C_RUN,  0, 8'h00, 4'd0, 0, 0, 0, 2'd0, 8'd0, 0, 8'h00);
    // LOAD accept with a simultaneous wr_valid: command wins.
    add("load_acc",      1, C_LOAD, 1, 8'hEE, 4'd0, 0, 1, 1, 2'd0, 8'd0, 0, 8'h00);
    for (int k = 0; k < 16; k++)
      add("load_wr", 0, C_NOP, 1, 8'(16 + k), 4'd0, 0, 1, 0, 2'd1, 8'd0, 0, 8'h00);
    add("load_a5",       0, C_NOP,  0, 8'h00, 4'd5,  0, 0, 0, 2'd0, 8'd0, 1, 8'h15);
    add("load_a15",      0, C_NOP,  0, 8'h00, 4'd15, 0, 0, 0, 2'd0, 8'd0, 1, 8'h1F);
    add("load_a0",       0, C_NOP,  0, 8'h00, 4'd0,  0, 1, 1, 2'd0, 8'd0, 1, 8'h10);
    // RUN 40 cycles; STEP ignored at 10, stray byte at 20, HALT on terminal cycle 40.
    add("run_acc",       1, C_RUN,  0, 8'h00, 4'd15, 0, 1, 1, 2'd0, 8'd0, 1, 8'h1F);
    for (int r = 1; r <= 40; r++)
      add("run_cyc", (r == 10 || r == 40), (r == 40) ? C_HALT : C_STEP,
          (r == 20), 8'hFF, 4'd15, (r % 4 == 0), 1, 1, 2'd2, 8'((r - 1) / 4), 1, 8'h1F);
    for (int k = 0; k < 3; k++)
      add("halt_after",  0, C_NOP,  0, 8'h00, 4'd15, 0, 1, 1, 2'd0, 8'd10, 1, 8'h1F);
    // CPU_RST from IDLE, then three STEPs with cmd_valid held high.
    add("crst_idle",     1, C_CRST, 0, 8'h00, 4'd0, 0, 1, 1, 2'd0, 8'd10, 0, 8'h00);
    add("crst_hold1",    0, C_NOP,  0, 8'h00, 4'd0, 0, 0, 0, 2'd0, 8'd0,  0, 8'h00);
    add("crst_hold2",    0, C_NOP,  0, 8'h00, 4'd0, 0, 0, 0, 2'd0, 8'd0,  0, 8'h00);
    for (int s = 0; s < 3; s++) begin
      add("step_acc",    1, C_STEP, 0, 8'h00, 4'd0, 0, 1, 1, 2'd0, 8'(s), 0, 8'h00);
      add("step_pulse",  1, C_STEP, 0, 8'h00, 4'd0, 1, 1, 0, 2'd3, 8'(s), 0, 8'h00);
    end
    add("step_done",     0, C_NOP,  0, 8'h00, 4'd0, 0, 1, 1, 2'd0, 8'd3, 0, 8'h00);
    // CPU_RST in RUN on the terminal cycle: pulse issued, then count clears.
    add("e_run_acc",     1, C_RUN,  0, 8'h00, 4'd0, 0, 1, 1, 2'd0, 8'd3, 0, 8'h00);
    for (int r = 1; r <= 3; r++)
      add("e_run",       0, C_NOP,  0, 8'h00, 4'd0, 0, 1, 1, 2'd2, 8'd3, 0, 8'h00);
    add("e_crst_term",   1, C_CRST, 0, 8'h00, 4'd0, 1, 1, 1, 2'd2, 8'd3, 0, 8'h00);
    add("e_hold1",       0, C_NOP,  0, 8'h00, 4'd0, 0, 0, 0, 2'd2, 8'd0, 0, 8'h00);
    add("e_hold2",       0, C_NOP,  0, 8'h00, 4'd0, 0, 0, 0, 2'd2, 8'd0, 0, 8'h00);
    add("e_live",        0, C_NOP,  0, 8'h00, 4'd0, 0, 1, 1, 2'd2, 8'd0, 0, 8'h00);
    add("e_first_tick",  0, C_NOP,  0, 8'h00, 4'd0, 1, 1, 1, 2'd2, 8'd0, 0, 8'h00);
    add("e_halt",        1, C_HALT, 0, 8'h00, 4'd0, 0, 1, 1, 2'd2, 8'd1, 0, 8'h00);
    add("e_idle",        0, C_NOP,  0, 8'h00, 4'd0, 0, 1, 1, 2'd0, 8'd1, 0, 8'h00);

    #1 n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'({en, nrst, rdy, st, cnt}), 0);
    n_reset = 1'b1;

    foreach (q[i]) begin
      cv = q[i].cv; cmd = q[i].cmd; wv = q[i].wv; wd = q[i].wd; addr = q[i].addr;
      #4;
      n_total++;
      if ({en, nrst, rdy, st, cnt} === {q[i].en, q[i].nrst, q[i].rdy, q[i].st, q[i].cnt} &&
          (!q[i].ci || instr === q[i].instr))
        n_pass++;
      else
        $display("FAIL %s[%0d]: got en=%b nrst=%b rdy=%b st=%0d cnt=%0d instr=%h want en=%b nrst=%b rdy=%b st=%0d cnt=%0d instr=%h",
                 q[i].name, i, en, nrst, rdy, st, cnt, instr,
                 q[i].en, q[i].nrst, q[i].rdy, q[i].st, q[i].cnt, q[i].instr);
      @(posedge clk);
      #1;
    end
    cv = 1'b0; wv = 1'b0;

    // Saturation: count starts at 1, 1100 cycles of RUN give far more than 254 ticks.
    cv = 1'b1; cmd = C_RUN;
    @(posedge clk); #1;
    cv = 1'b0;
    repeat (1100) @(posedge clk);
    #1;
    chk("sat_cnt", int'(cnt), 255);
    chk("sat_state", int'(st), 2);
    cv = 1'b1; cmd = C_HALT;
    @(posedge clk); #1;
    cv = 1'b0;
    #2 chk("sat_halt_state", int'(st), 0);

    // n_reset mid-LOAD: partial program survives, pointer restarts at 0.
    cv = 1'b1; cmd = C_LOAD;
    @(posedge clk); #1;
    cv = 1'b0; wv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wd = 8'(8'hA0 + k);
      @(posedge clk); #1;
    end
    wv = 1'b0;
    n_reset = 1'b0;
    #2;
    chk("midload_rst_state", int'({st, nrst, rdy}), 0);
    n_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midload_ready", int'({rdy, nrst}), 3);
    addr = 4'd0; #1 chk("midload_mem0", int'(instr), 8'hA0);
    addr = 4'd2; #1 chk("midload_mem2", int'(instr), 8'hA2);
    addr = 4'd3; #1 chk("midload_mem3_old", int'(instr), 8'h13);
    @(posedge clk); #1;
    cv = 1'b1; cmd = C_LOAD;
    @(posedge clk); #1;
    cv = 1'b0; wv = 1'b1; wd = 8'hB0;
    @(posedge clk); #1;
    wv = 1'b0;
    addr = 4'd0; #1 chk("reload_mem0", int'(instr), 8'hB0);
    addr = 4'd1; #1 chk("reload_mem1", int'(instr), 8'hA1);
    chk("reload_state", int'(st), 1);
    n_reset = 1'b0;
    #2 n_reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;

`ifdef TD4_CTRL_BREAK_EN
    begin
      int pc;
      int hits;
      int en_at_hit;
      int pc_at_hit;
      cv = 1'b1; cmd = C_CRST;
      @(posedge clk); #1;
      cv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bp_en = 1'b1; bp_addr = 4'd6;
      pc = 0; hits = 0; en_at_hit = 0; pc_at_hit = -1;
      addr = 4'd0;
      cv = 1'b1; cmd = C_RUN;
      @(posedge clk); #1;
      cv = 1'b0;
      for (int c = 0; c < 60; c++) begin
        addr = 4'(pc);
        #1;
        if (bp_hit) begin
          hits++;
          en_at_hit = int'(en);
          pc_at_hit = pc;
        end
        if (en) pc++;
        @(posedge clk); #1;
      end
      chk("bp_hits", hits, 1);
      chk("bp_pc_at_hit", pc_at_hit, 6);
      chk("bp_en_at_hit", en_at_hit, 0);
      chk("bp_final_pc", pc, 6);
      chk("bp_state", int'(st), 0);
      chk("bp_exec", int'(cnt), 6);
      addr = 4'd6;
      cv = 1'b1; cmd = C_STEP;
      @(posedge clk); #1;
      cv = 1'b0;
      #1 chk("bp_step_en", int'(en), 1);
      @(posedge clk); #1;
      chk("bp_step_exec", int'(cnt), 7);
      chk("bp_step_state", int'(st), 0);
      bp_en = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
